// File: rtl/hex_dump.sv
// Dumps a RAM address range as an ASCII Intel HEX stream, one character per valid/rdy handshake.
// Define HEX_CRLF_EN to end each record with CR LF; otherwise records end with LF only.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start
// S_COLON   | presenting ':' record mark
// S_LEN_*   | presenting record length, high/low nibble
// S_ADDR_*  | presenting record address, nibble 3 (MSN) down to 0
// S_TYPE_*  | presenting record type (00 data, 01 EOF)
// S_FETCH   | RAM read strobe for the next data byte
// S_WAIT    | RAM data arriving, captured into data_byte
// S_DATA_*  | presenting data byte, high/low nibble
// S_CSUM_*  | presenting record checksum, high/low nibble
// S_CR      | presenting CR (HEX_CRLF_EN only)
// S_LF      | presenting LF, then next record, EOF record or done
// S_DONE    | one-cycle done pulse
module hex_dump #(
    parameter int REC_LEN = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    output logic        busy,
    output logic        done,
    output logic        rd,
    output logic [15:0] addr,
    input  logic [7:0]  data,
    output logic [7:0]  chr,
    output logic        valid,
    input  logic        rdy
);

    typedef enum logic [4:0] {
        S_IDLE, S_COLON, S_LEN_HI, S_LEN_LO,
        S_ADDR_3, S_ADDR_2, S_ADDR_1, S_ADDR_0,
        S_TYPE_HI, S_TYPE_LO, S_FETCH, S_WAIT,
        S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO,
`ifdef HEX_CRLF_EN
        S_CR,
`endif
        S_LF, S_DONE
    } state_t;

    state_t      state, next;
    logic [16:0] ptr;         // 17 bits so a dump ending at FFFF never wraps to 0000
    logic [15:0] end_r;
    logic [15:0] rec_addr;
    logic [7:0]  rec_len;
    logic [7:0]  bytes_left;
    logic [7:0]  data_byte;
    logic [7:0]  dsum;
    logic        eof_r;
    logic        load_rec;

    logic [16:0] src_ptr, src_end, remain;
    logic        has_data;
    logic [7:0]  next_len, hdr_sum, csum;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // record setup reads the start ports directly when launching from idle
    always_comb begin
        src_ptr  = (state == S_IDLE) ? {1'b0, start_addr} : ptr;
        src_end  = (state == S_IDLE) ? {1'b0, end_addr} : {1'b0, end_r};
        has_data = (src_ptr <= src_end);
        remain   = src_end - src_ptr + 17'd1;
        next_len = (remain > 17'(REC_LEN)) ? 8'(REC_LEN) : remain[7:0];
        hdr_sum  = rec_len + rec_addr[15:8] + rec_addr[7:0] + {7'b0, eof_r};
        csum     = ~(hdr_sum + dsum) + 8'd1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next     = state;
        chr      = 8'h00;
        valid    = 1'b0;
        rd       = 1'b0;
        load_rec = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                load_rec = 1'b1;
                next     = S_COLON;
            end
            S_COLON:   begin valid = 1'b1; chr = 8'h3A;                     if (rdy) next = S_LEN_HI;  end
            S_LEN_HI:  begin valid = 1'b1; chr = hex(rec_len[7:4]);         if (rdy) next = S_LEN_LO;  end
            S_LEN_LO:  begin valid = 1'b1; chr = hex(rec_len[3:0]);         if (rdy) next = S_ADDR_3;  end
            S_ADDR_3:  begin valid = 1'b1; chr = hex(rec_addr[15:12]);      if (rdy) next = S_ADDR_2;  end
            S_ADDR_2:  begin valid = 1'b1; chr = hex(rec_addr[11:8]);       if (rdy) next = S_ADDR_1;  end
            S_ADDR_1:  begin valid = 1'b1; chr = hex(rec_addr[7:4]);        if (rdy) next = S_ADDR_0;  end
            S_ADDR_0:  begin valid = 1'b1; chr = hex(rec_addr[3:0]);        if (rdy) next = S_TYPE_HI; end
            S_TYPE_HI: begin valid = 1'b1; chr = hex(4'h0);                 if (rdy) next = S_TYPE_LO; end
            S_TYPE_LO: begin
                valid = 1'b1;
                chr   = hex({3'b0, eof_r});
                if (rdy) next = (rec_len == 8'd0) ? S_CSUM_HI : S_FETCH;
            end
            S_FETCH:   begin rd = 1'b1; next = S_WAIT; end
            S_WAIT:    next = S_DATA_HI;
            S_DATA_HI: begin valid = 1'b1; chr = hex(data_byte[7:4]);       if (rdy) next = S_DATA_LO; end
            S_DATA_LO: begin
                valid = 1'b1;
                chr   = hex(data_byte[3:0]);
                if (rdy) next = (bytes_left == 8'd1) ? S_CSUM_HI : S_FETCH;
            end
            S_CSUM_HI: begin valid = 1'b1; chr = hex(csum[7:4]);            if (rdy) next = S_CSUM_LO; end
`ifdef HEX_CRLF_EN
            S_CSUM_LO: begin valid = 1'b1; chr = hex(csum[3:0]);            if (rdy) next = S_CR;      end
            S_CR:      begin valid = 1'b1; chr = 8'h0D;                     if (rdy) next = S_LF;      end
`else
            S_CSUM_LO: begin valid = 1'b1; chr = hex(csum[3:0]);            if (rdy) next = S_LF;      end
`endif
            S_LF: begin
                valid = 1'b1;
                chr   = 8'h0A;
                if (rdy) begin
                    if (eof_r) begin
                        next = S_DONE;
                    end else begin
                        load_rec = 1'b1;
                        next     = S_COLON;
                    end
                end
            end
            S_DONE:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr        <= '0;
            end_r      <= '0;
            rec_addr   <= '0;
            rec_len    <= '0;
            bytes_left <= '0;
            data_byte  <= '0;
            dsum       <= '0;
            eof_r      <= 1'b0;
        end else begin
            if (load_rec) begin
                if (state == S_IDLE) begin
                    ptr   <= {1'b0, start_addr};
                    end_r <= end_addr;
                end
                eof_r      <= !has_data;
                rec_addr   <= has_data ? src_ptr[15:0] : 16'h0000;
                rec_len    <= has_data ? next_len : 8'd0;
                bytes_left <= has_data ? next_len : 8'd0;
                dsum       <= '0;
            end
            if (state == S_FETCH) ptr <= ptr + 17'd1;
            if (state == S_WAIT) begin
                data_byte <= data;
                dsum      <= dsum + data;
            end
            if (state == S_DATA_LO && rdy) bytes_left <= bytes_left - 8'd1;
        end
    end

    assign addr = ptr[15:0];
    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_hex_dump.sv
// Directed bench for hex_dump: known RAM images, hand-computed HEX streams, backpressure and abort.
// Follows the DUT build: EOL expectations switch on HEX_CRLF_EN.
module tb_hex_dump;

    logic        clk = 1'b0;
    logic        clr, start, busy, done, rd, valid, rdy;
    logic [15:0] start_addr, end_addr, addr;
    logic [7:0]  data, chr;

    always #5 clk = ~clk;

    hex_dump #(.REC_LEN(16)) dut (
        .clk(clk), .clr(clr), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy), .done(done), .rd(rd), .addr(addr), .data(data),
        .chr(chr), .valid(valid), .rdy(rdy)
    );

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (rd) data <= mem[addr];

    int  checks = 0, errors = 0;
    int  rd_cnt, rd_zero_cnt, done_cnt, viol_cnt, gap, max_gap;
    byte got_q[$], exp_q[$];
    bit  rand_rdy = 1'b0;
    logic       pv = 1'b0, pr = 1'b1;
    logic [7:0] pc = 8'h00;

    always @(negedge clk) begin
        if (rd) begin
            rd_cnt++;
            if (addr == 16'h0000) rd_zero_cnt++;
        end
        if (done) done_cnt++;
        if (valid && rdy) got_q.push_back(chr);
        if (pv && !pr && (!valid || chr != pc)) viol_cnt++;
        pv = valid; pr = rdy; pc = chr;
        if (busy && !valid) begin
            gap++;
            if (gap > max_gap) max_gap = gap;
        end else begin
            gap = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic add_eol();
`ifdef HEX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        rd_cnt = 0; rd_zero_cnt = 0; done_cnt = 0; viol_cnt = 0; gap = 0; max_gap = 0;
    endtask

    task automatic compare_stream(input string tag);
        int mism = 0;
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mism++;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        check({tag, "_chars_bad"}, mism, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_gap_ok"}, (max_gap <= 2), 1);
    endtask

    // poke: pulse start again with a different range while the dump is in progress
    task automatic run_dump(input string tag, input logic [15:0] s, input logic [15:0] e, input bit poke);
        bit seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = s; end_addr = e;
        @(posedge clk); #1;
        start = 1'b0; start_addr = 16'hAAAA; end_addr = 16'h5555;
        check({tag, "_first"}, {busy, valid, chr}, {1'b1, 1'b1, 8'h3A});
        if (poke) begin
            repeat (5) @(posedge clk);
            #1; start = 1'b1; start_addr = 16'h0010; end_addr = 16'h000F;
            @(posedge clk); #1; start = 1'b0;
        end
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        @(negedge clk);
        check({tag, "_idle_after"}, {busy, done, valid}, 3'b000);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0; rdy = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
        mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h02;
        mem[16'h0002] = 8'h03; mem[16'h0003] = 8'h04;
        for (int i = 0; i < 18; i++) mem[16'h0100 + i] = 8'(i);
        mem[16'hFFFE] = 8'hAB; mem[16'hFFFF] = 8'hCD;
        #1;
        check("reset_outputs", {busy, done, rd, addr, chr, valid}, 27'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        // basic four-byte dump
        clear_mon();
        add_exp(":0400000001020304F2"); add_eol(); add_exp(":00000001FF"); add_eol();
        run_dump("t1", 16'h0000, 16'h0003, 1'b0);
        compare_stream("t1");
        check("t1_rd_cnt", rd_cnt, 4);

        // 18 bytes split 16 + 2
        clear_mon();
        add_exp(":10010000000102030405060708090A0B0C0D0E0F77"); add_eol();
        add_exp(":020110001011CC"); add_eol();
        add_exp(":00000001FF"); add_eol();
        run_dump("t2", 16'h0100, 16'h0111, 1'b0);
        compare_stream("t2");
        check("t2_rd_cnt", rd_cnt, 18);

        // random backpressure
        clear_mon();
        rand_rdy = 1'b1;
        add_exp(":0400000001020304F2"); add_eol(); add_exp(":00000001FF"); add_eol();
        run_dump("t3", 16'h0000, 16'h0003, 1'b0);
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        check("t3_len", got_q.size(), exp_q.size());
        begin
            int mism = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
            check("t3_chars_bad", mism, 0);
        end
        check("t3_hold_viol", viol_cnt, 0);
        check("t3_rd_cnt", rd_cnt, 4);

        // empty range
        clear_mon();
        add_exp(":00000001FF"); add_eol();
        run_dump("t4", 16'h0010, 16'h000F, 1'b0);
        compare_stream("t4");
        check("t4_rd_cnt", rd_cnt, 0);

        // top of address space
        clear_mon();
        add_exp(":02FFFE00ABCD89"); add_eol(); add_exp(":00000001FF"); add_eol();
        run_dump("t6", 16'hFFFE, 16'hFFFF, 1'b0);
        compare_stream("t6");
        check("t6_rd_cnt", rd_cnt, 2);
        check("t6_rd_zero", rd_zero_cnt, 0);

        // abort mid-data, then restart with an ignored start while busy
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 16'h0100; end_addr = 16'h0111;
        @(posedge clk); #1; start = 1'b0;
        begin
            bit reached = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (got_q.size() >= 12) begin reached = 1'b1; break; end
            end
            check("t5_reached_data", reached, 1'b1);
        end
        #2 clr = 1'b1;
        #1;
        check("t5_abort_outputs", {busy, done, rd, addr, chr, valid}, 27'd0);
        @(posedge clk); #1 clr = 1'b0;
        clear_mon();
        add_exp(":0400000001020304F2"); add_eol(); add_exp(":00000001FF"); add_eol();
        run_dump("t5", 16'h0000, 16'h0003, 1'b1);
        compare_stream("t5");
        check("t5_rd_cnt", rd_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
